// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD DMA blocks.
//   - AXI4 write-channel constant field encodings used by the fill engine
//   - framebuffer geometry (320x240 RGB565) and derived burst count
//   - fill engine state enum
package lcd_pkg;

  // Burst length in 32-bit beats: 16 beats = 64 B = 32 RGB565 pixels.
  localparam int LCD_LEN   = 16;
  localparam int LCD_CNT_W = 12;

  localparam logic [2:0] AXI_SIZE_32    = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [3:0] AXI_CACHE      = 4'd3;

  localparam int LCD_H_RES            = 320;
  localparam int LCD_V_RES            = 240;
  localparam int LCD_BURSTS_PER_FRAME = 2400;

  // Fill regions must start on a 64 B boundary.
  localparam int FILL_ALIGN_BITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } fill_state_e;

endpackage

// File: rtl/lcd_frame_fill.sv
// lcd_frame_fill: AXI4 write-only DMA that paints a framebuffer region with
// one RGB565 colour, one LEN-beat INCR burst at a time.
//   AXI_ACLK / AXI_ARESET     clock, synchronous active-high reset
//   fill_start                one-cycle request (ignored while busy)
//   fill_address/color/bursts base byte address (64 B aligned), colour, count
//   fill_busy                 high while a fill is running
//   fill_done                 one-cycle pulse on completion or rejection
//   fill_error                sticky: bad BRESP or misaligned start
//   M_AXI_AW*/W*/B*           AXI4 write address, data and response channels
module lcd_frame_fill
  import lcd_pkg::*;
#(
  parameter int LEN   = LCD_LEN,
  parameter int CNT_W = LCD_CNT_W
) (
  input  logic             AXI_ACLK,
  input  logic             AXI_ARESET,
  input  logic             fill_start,
  input  logic [31:0]      fill_address,
  input  logic [15:0]      fill_color,
  input  logic [CNT_W-1:0] fill_bursts,
  output logic             fill_busy,
  output logic             fill_done,
  output logic             fill_error,
  output logic [31:0]      M_AXI_AWADDR,
  output logic [7:0]       M_AXI_AWLEN,
  output logic [2:0]       M_AXI_AWSIZE,
  output logic [1:0]       M_AXI_AWBURST,
  output logic [3:0]       M_AXI_AWCACHE,
  output logic             M_AXI_AWVALID,
  input  logic             M_AXI_AWREADY,
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WLAST,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_WREADY,
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY
);

  localparam int BW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(LEN - 1);
  localparam logic [31:0]   BURST_BYTES = 32'(LEN * 4);

  fill_state_e      state;
  logic [31:0]      addr;
  logic [15:0]      color;
  logic [CNT_W-1:0] remaining;
  logic [BW-1:0]    beat;
  logic             beat_last;

  assign beat_last = (beat == BEAT_LAST);

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state      <= ST_IDLE;
      addr       <= '0;
      color      <= '0;
      remaining  <= '0;
      beat       <= '0;
      fill_done  <= 1'b0;
      fill_error <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            // Misalignment wins over a zero count: it is reported as an error.
            if (fill_address[FILL_ALIGN_BITS-1:0] != '0) begin
              fill_error <= 1'b1;
              fill_done  <= 1'b1;
            end else if (fill_bursts == '0) begin
              fill_error <= 1'b0;
              fill_done  <= 1'b1;
            end else begin
              addr       <= fill_address;
              color      <= fill_color;
              remaining  <= fill_bursts;
              beat       <= '0;
              fill_error <= 1'b0;
              state      <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (M_AXI_AWREADY) state <= ST_DATA;
        end
        ST_DATA: begin
          if (M_AXI_WREADY) begin
            if (beat_last) begin
              beat  <= '0;
              state <= ST_RESP;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (M_AXI_BVALID) begin
            // Error responses are recorded but the fill keeps going.
            if (M_AXI_BRESP != 2'b00) fill_error <= 1'b1;
            addr      <= addr + BURST_BYTES;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state     <= ST_IDLE;
              fill_done <= 1'b1;
            end else begin
              state <= ST_ADDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Channel valids decode straight from state, so AW and W can never overlap
  // and nothing combinationally depends on the slave's ready inputs.
  assign fill_busy     = (state != ST_IDLE);
  assign M_AXI_AWVALID = (state == ST_ADDR);
  assign M_AXI_WVALID  = (state == ST_DATA);
  assign M_AXI_BREADY  = (state == ST_RESP);
  assign M_AXI_WLAST   = (state == ST_DATA) && beat_last;

  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = 8'(LEN - 1);
  assign M_AXI_AWSIZE  = AXI_SIZE_32;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWCACHE = AXI_CACHE;
  assign M_AXI_WDATA   = {color, color};
  assign M_AXI_WSTRB   = 4'hf;

endmodule

// File: tb/tb_lcd_frame_fill.sv
module tb_lcd_frame_fill;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill_start = 1'b0;
  logic [31:0] fill_address = '0;
  logic [15:0] fill_color = '0;
  logic [11:0] fill_bursts = '0;
  logic        fill_busy, fill_done, fill_error;
  logic [31:0] AWADDR, WDATA;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, BRESP = 2'b00;
  logic [3:0]  AWCACHE, WSTRB;
  logic        AWVALID, WLAST, WVALID, BREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;

  lcd_frame_fill dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .fill_start(fill_start), .fill_address(fill_address),
    .fill_color(fill_color), .fill_bursts(fill_bursts),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_error(fill_error),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWCACHE(AWCACHE),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a fill is a list of m_n bursts at base + k*64, each 16
  // beats of {color,color}, each followed by one response.
  bit          m_busy = 0, m_err = 0, m_done = 0;
  logic [31:0] m_base = '0;
  logic [15:0] m_color = '0;
  int          m_n = 0, m_aw = 0, m_beat = 0, m_b = 0;

  // Slave behaviour knobs.
  int cfg_aw_delay = 0, cfg_b_delay = 0, cfg_err_burst = -1;
  bit cfg_wrand = 0;
  int aw_wait = 0, b_wait = 0;

  // Per-test statistics.
  int          st_aw, st_beats, st_wlast, st_done, st_data_lit;
  logic [31:0] st_aw0, st_aw1, st_last_aw;
  logic        st_err_done;

  task automatic clr_stats();
    st_aw = 0; st_beats = 0; st_wlast = 0; st_done = 0; st_data_lit = 0;
    st_aw0 = '0; st_aw1 = '0; st_last_aw = '0; st_err_done = 1'b0;
  endtask

  // Everything is sampled and driven on the falling edge; the DUT's outputs
  // are settled then and the ready/response inputs hold through the next
  // rising edge.
  always @(negedge clk) begin
    bit exp_awv, exp_wv, exp_br, aw_hs, w_hs, b_hs;
    exp_awv = m_busy && (m_aw == m_b);
    exp_wv  = m_busy && (m_aw > m_b) && (m_beat < 16);
    exp_br  = m_busy && (m_aw > m_b) && (m_beat == 16);
    chk_eq("fill_busy", fill_busy, m_busy);
    chk_eq("fill_done", fill_done, m_done);
    chk_eq("fill_error", fill_error, m_err);
    chk_eq("awvalid", AWVALID, exp_awv);
    chk_eq("wvalid", WVALID, exp_wv);
    chk_eq("bready", BREADY, exp_br);
    chk_eq("aw_w_overlap", AWVALID && WVALID, 0);
    chk_eq("awlen", AWLEN, 15);
    chk_eq("awsize", AWSIZE, 2);
    chk_eq("awburst", AWBURST, 1);
    chk_eq("awcache", AWCACHE, 3);
    if (AWVALID && exp_awv) chk_eq("awaddr", AWADDR, m_base + 32'(m_aw * 64));
    if (WVALID && exp_wv) begin
      chk_eq("wdata", WDATA, {m_color, m_color});
      chk_eq("wstrb", WSTRB, 4'hf);
      chk_eq("wlast", WLAST, m_beat == 15);
    end
    if (fill_done) begin
      st_done++;
      st_err_done = fill_error;
    end
    m_done = 0;

    AWREADY = AWVALID && (aw_wait >= cfg_aw_delay);
    if (AWVALID) aw_wait++;
    WREADY = cfg_wrand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (BREADY) begin
      BVALID = (b_wait >= cfg_b_delay);
      b_wait++;
    end else begin
      BVALID = 1'b0;
    end
    BRESP = (BVALID && m_b == cfg_err_burst) ? 2'b10 : 2'b00;
    aw_hs = AWVALID && AWREADY;
    w_hs  = WVALID && WREADY;
    b_hs  = BVALID && BREADY;

    if (rst) begin
      m_busy = 0; m_err = 0; m_n = 0; m_aw = 0; m_beat = 0; m_b = 0;
      m_base = '0; m_color = '0; aw_wait = 0; b_wait = 0;
    end else begin
      if (!m_busy && fill_start) begin
        if (fill_address[5:0] != 0) begin
          m_err = 1; m_done = 1;
        end else if (fill_bursts == 0) begin
          m_err = 0; m_done = 1;
        end else begin
          m_busy = 1; m_err = 0; m_base = fill_address; m_color = fill_color;
          m_n = int'(fill_bursts); m_aw = 0; m_beat = 0; m_b = 0;
        end
      end
      if (aw_hs) begin
        m_aw++; aw_wait = 0; st_aw++;
        if (st_aw == 1) st_aw0 = AWADDR;
        if (st_aw == 2) st_aw1 = AWADDR;
        st_last_aw = AWADDR;
      end
      if (w_hs) begin
        m_beat++; st_beats++;
        if (WLAST) st_wlast++;
        if (WDATA === 32'hF800F800) st_data_lit++;
      end
      if (b_hs) begin
        m_b++; m_beat = 0; b_wait = 0;
        if (BRESP != 2'b00) m_err = 1;
        if (m_b == m_n) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  task automatic start_fill(input logic [31:0] a, input logic [15:0] c, input logic [11:0] n);
    @(posedge clk); #1;
    fill_address = a; fill_color = c; fill_bursts = n; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
  endtask

  // Waits for the model to go idle; optionally throws stray start pulses at
  // the DUT while it is busy (never in the final burst, so none can land on
  // the idle edge).
  task automatic wait_fill(input int budget, input bit spam);
    int i = 0;
    do begin
      @(posedge clk); #1;
      fill_start = spam && m_busy && (m_n - m_b > 1) && ($urandom_range(0, 199) == 0);
      if (fill_start) fill_address = {$urandom, 6'b0} >> 6 << 6;
      @(negedge clk);
      i++;
    end while (m_busy && i < budget);
    fill_start = 1'b0;
    if (m_busy) chk_eq("fill_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic basic_fill();
    clr_stats();
    start_fill(32'h1000_0000, 16'hF800, 12'd2);
    wait_fill(500, 0);
    chk_eq("b_aw_count", st_aw, 2);
    chk_eq("b_aw0", st_aw0, 32'h1000_0000);
    chk_eq("b_aw1", st_aw1, 32'h1000_0040);
    chk_eq("b_beats", st_beats, 32);
    chk_eq("b_data_lit", st_data_lit, 32);
    chk_eq("b_wlast", st_wlast, 2);
    chk_eq("b_done", st_done, 1);
    chk_eq("b_err", st_err_done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_awaddr", AWADDR, 0);
    chk_eq("rst_wdata", WDATA, 0);
    chk_eq("rst_valids", {AWVALID, WVALID, BREADY, WLAST}, 0);
    chk_eq("rst_flags", {fill_busy, fill_done, fill_error}, 0);

    basic_fill();

    // Stalled slave: slow AW, 50% WREADY.
    cfg_aw_delay = 5; cfg_wrand = 1;
    clr_stats();
    start_fill(32'h2000_0080, 16'h07E0, 12'd3);
    wait_fill(2000, 0);
    chk_eq("s_beats", st_beats, 48);
    chk_eq("s_wlast", st_wlast, 3);
    chk_eq("s_last_aw", st_last_aw, 32'h2000_0100);
    chk_eq("s_done", st_done, 1);
    cfg_aw_delay = 0; cfg_wrand = 0;

    // Error response on the middle burst; a clean fill then clears it.
    cfg_err_burst = 1;
    clr_stats();
    start_fill(32'h0000_1000, 16'h001F, 12'd3);
    wait_fill(500, 0);
    chk_eq("e_aw_count", st_aw, 3);
    chk_eq("e_err_at_done", st_err_done, 1);
    cfg_err_burst = -1;
    clr_stats();
    start_fill(32'h0000_2000, 16'h001F, 12'd1);
    wait_fill(500, 0);
    chk_eq("e_clean_err", st_err_done, 0);

    // Rejected starts.
    clr_stats();
    start_fill(32'h1000_0004, 16'hFFFF, 12'd2);
    wait_fill(10, 0);
    chk_eq("mis_aw", st_aw, 0);
    chk_eq("mis_done", st_done, 1);
    chk_eq("mis_err", st_err_done, 1);
    clr_stats();
    start_fill(32'h1000_0000, 16'hFFFF, 12'd0);
    wait_fill(10, 0);
    chk_eq("zero_aw", st_aw, 0);
    chk_eq("zero_done", st_done, 1);
    chk_eq("zero_err", st_err_done, 0);

    // Reset during the data phase.
    clr_stats();
    start_fill(32'h1000_0000, 16'h1234, 12'd2);
    for (int i = 0; i < 100 && st_beats < 6; i++) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("mr_valids", {AWVALID, WVALID, BREADY, fill_busy}, 0);
    repeat (5) @(negedge clk);
    chk_eq("mr_no_done", st_done, 0);
    basic_fill();

    // Random fills with random slave behaviour.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 4);
      cfg_aw_delay = $urandom_range(0, 3);
      cfg_b_delay = $urandom_range(0, 2);
      cfg_wrand = 1'($urandom_range(0, 1));
      cfg_err_burst = int'($urandom_range(0, 5)) - 1;
      clr_stats();
      start_fill({$urandom} & 32'hFFFF_FFC0, 16'($urandom), 12'(n));
      wait_fill(3000, 1);
      chk_eq("r_aw_count", st_aw, n);
      chk_eq("r_beats", st_beats, n * 16);
      chk_eq("r_done", st_done, 1);
      chk_eq("r_err", st_err_done, (cfg_err_burst >= 0 && cfg_err_burst < n));
    end
    cfg_aw_delay = 0; cfg_b_delay = 0; cfg_wrand = 0; cfg_err_burst = -1;

    // Full frame with stray starts while busy.
    clr_stats();
    start_fill(32'h0, 16'hAAAA, 12'(LCD_BURSTS_PER_FRAME));
    wait_fill(60000, 1);
    chk_eq("f_aw_count", st_aw, 2400);
    chk_eq("f_last_aw", st_last_aw, 32'h0002_57C0);
    chk_eq("f_done", st_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_fill.md
LCD_FRAME_FILL -- requirements
Module: lcd_frame_fill

Interface
REQ-001 Parameter LEN, default 16, sets AXI write burst length in 32-bit beats (16 beats = 64 B = 32 RGB565 pixels).
REQ-002 Parameter CNT_W, default 12, sets the width of the burst count (2400 bursts = one 320x240 frame).
REQ-003 AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 fill_start  in  1  one-cycle request to begin a fill.
REQ-006 fill_address  in  32  byte base address of the framebuffer region.
REQ-007 fill_color  in  16  RGB565 fill value.
REQ-008 fill_bursts  in  CNT_W  number of LEN-beat bursts to write.
REQ-009 fill_busy  out  1  high while a fill is in progress.
REQ-010 fill_done  out  1  one-cycle pulse when a fill completes or is rejected.
REQ-011 fill_error  out  1  sticky; BRESP!=0 seen, or misaligned address rejected.
REQ-012 M_AXI_AWADDR out 32, AWLEN out 8, AWSIZE out 3, AWBURST out 2, AWCACHE out 4, AWVALID out 1, AWREADY in 1: AXI4 write address channel.
REQ-013 M_AXI_WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1, WREADY in 1: AXI4 write data channel.
REQ-014 M_AXI_BRESP in 2, BVALID in 1, BREADY out 1: AXI4 write response channel.

Function
REQ-015 States: IDLE, ADDR, DATA, RESP; at most one burst outstanding.
REQ-016 IDLE: fill_start with fill_address[5:0]==0 and fill_bursts!=0 latches address, color and count, clears fill_error, and moves to ADDR; AWVALID is asserted the next cycle.
REQ-017 IDLE: fill_start with fill_address[5:0]!=0 sets fill_error, pulses fill_done the next cycle and stays in IDLE with no AXI traffic.
REQ-018 IDLE: fill_start with fill_bursts==0 pulses fill_done the next cycle with fill_error cleared and no AXI traffic.
REQ-019 fill_start while not IDLE is ignored.
REQ-020 ADDR: AWVALID=1 with AWADDR=current address, AWLEN=LEN-1, AWSIZE=2, AWBURST=1 (INCR), AWCACHE=3; AWADDR stays stable until AWREADY; on handshake go to DATA.
REQ-021 DATA: WVALID=1, WDATA={color,color}, WSTRB=4'hf; the beat counter advances only on WVALID&WREADY; WLAST=1 exactly on beat LEN-1; on the last handshake go to RESP.
REQ-022 AWVALID and WVALID are never high in the same cycle.
REQ-023 RESP: BREADY=1 (0 in all other states); on BVALID, BRESP!=0 sets fill_error, address += LEN*4, and remaining -= 1.
REQ-024 RESP: after BVALID, go to IDLE if remaining reaches 0 (fill_done pulses the same cycle as the transition), otherwise go to ADDR.
REQ-025 An error response does not abort the fill; all bursts are issued.
REQ-026 fill_busy = (state != IDLE).
REQ-027 Address arithmetic is 32-bit modulo 2^32; no 4 KB crossing occurs because bursts are 64 B aligned.
REQ-028 The remaining-burst counter is CNT_W wide; 2^CNT_W-1 bursts is the maximum supported count.

Reset
REQ-029 On AXI_ARESET: state=IDLE, AWVALID=WVALID=BREADY=0, WLAST=0, fill_busy=fill_done=fill_error=0, AWADDR=0, WDATA=0, counters=0; constant AW fields hold their REQ-020 values.
REQ-030 Reset mid-burst drops the transaction immediately; no completion is awaited and no fill_done is produced.

Structure
REQ-031 Shared package lcd_pkg holds LEN default, AXI_SIZE_32=2, AXI_BURST_INCR=1, AXI_CACHE=3, frame geometry 320x240, bursts-per-frame 2400, and the fill state enum.
REQ-032 Single module with no sub-module; instantiated beside the read DMA in the top level and shares the M_AXI write channels that the top level currently ties off.

Verification
REQ-033 Setup: start, address 0x1000_0000, color 0xF800, bursts 2, AWREADY/WREADY/BVALID always ready. Required: AWADDR 0x1000_0000 then 0x1000_0040; 32 beats of 0xF800F800; WLAST on beats 16 and 32; fill_done once; fill_error 0.
REQ-034 Setup: WREADY random at 50%, AWREADY delayed 5 cycles. Required: AWADDR and WDATA stable while stalled, exactly 16 beats per burst, no overlap of AWVALID and WVALID.
REQ-035 Setup: BRESP=2'b10 on burst 1 of 3. Required: all 3 bursts still issued, fill_error=1 at fill_done; a following clean start clears fill_error.
REQ-036 Setup: start with address 0x1000_0004. Required: no AWVALID, fill_error=1, fill_done the next cycle. Setup: start with bursts 0. Required: fill_done, fill_error 0.
REQ-037 Setup: AXI_ARESET asserted during beat 7. Required: next cycle IDLE with all valids 0 and no fill_done; a new start then behaves as in REQ-033.
REQ-038 Setup: full frame, 2400 bursts from 0x0. Required: last AWADDR 0x0002_57C0, fill_done once, fill_start pulses during busy ignored.
